// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dm_pkg
//  Description : Shared constants, request-type encoding and helpers for the
//                byte-enabled data memory dm_param.
//  Revision    : 1.0 - initial release
// ============================================================================
package dm_pkg;

  // Default geometry: 8192 words of 32 bits, 13-bit word address
  localparam int DM_DATA_W = 32;
  localparam int DM_ADDR_W = 13;
  localparam int DM_DEPTH  = 8192;

  // Request type decoded from the re/we pair each cycle
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD       = 2'd1,
    WR       = 2'd2,
    CONFLICT = 2'd3
  } req_e;

  // Map the raw strobes onto a request type
  function automatic req_e decode_req(input logic re, input logic we);
    req_e v;
    case ({re, we})
      2'b10:   v = RD;
      2'b01:   v = WR;
      2'b11:   v = CONFLICT;
      default: v = IDLE;
    endcase
    return v;
  endfunction

  // 8-bit increment that sticks at 255 instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_rd_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : dm_rd_pipe
//  Description : Optional extra read-output register stage (data + valid).
//                RD_PIPE=1 adds one register, RD_PIPE=0 is a pure bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_rd_pipe #(
  parameter int DATA_W  = 32,
  parameter int RD_PIPE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_data
);

  generate
    if (RD_PIPE == 1) begin : g_pipe
      logic              r_vld;
      logic [DATA_W-1:0] r_data;

      // Extra stage: valid follows input, data only captured on valid so it holds otherwise
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld  <= 1'b0;
          r_data <= '0;
        end else begin
          r_vld <= i_vld;
          if (i_vld) begin
            r_data <= i_data;
          end
        end
      end

      assign o_vld  = r_vld;
      assign o_data = r_data;
    end else begin : g_bypass
      // Clock and reset have no load in the bypass configuration
      logic w_unused_clk;
      assign w_unused_clk = clk ^ rst_n;

      assign o_vld  = i_vld;
      assign o_data = i_data;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/dm_param.sv
`default_nettype none
// ============================================================================
//  Module      : dm_param
//  Description : Single-port byte-enabled data memory with registered read,
//                optional extra read stage, request rejection (conflict or
//                out-of-range) with a one-cycle err pulse and a saturating
//                error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_param
  import dm_pkg::*;
#(
  parameter int DATA_W  = DM_DATA_W,
  parameter int ADDR_W  = DM_ADDR_W,
  parameter int DEPTH   = DM_DEPTH,
  parameter int RD_PIPE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                re,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wrt_data,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_vld,
  output logic                err,
  output logic [7:0]          err_cnt
);

  localparam int              NB      = DATA_W / 8;
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable
  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);

  req_e              w_req;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic              w_rd;
  logic              w_wr_ok;
  logic              w_rej;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_vld;
  logic              r_err;
  logic [7:0]        r_err_cnt;

  // Requests seen while reset is low are treated as idle so memory is untouched
  assign w_req      = rst_n ? decode_req(re, we) : IDLE;
  assign w_in_range = ({1'b0, addr} < C_DEPTH);
  assign w_idx      = addr[IDX_W-1:0];
  assign w_rd       = (w_req == RD);
  assign w_wr_ok    = (w_req == WR) && w_in_range;
  assign w_rej      = (w_req == CONFLICT) ||
                      (((w_req == RD) || (w_req == WR)) && !w_in_range);

  // Memory array: per-lane write, never reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          r_mem[w_idx][8*i +: 8] <= wrt_data[8*i +: 8];
        end
      end
    end
  end

  // Registered read port: out-of-range reads still answer, with zero data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_vld <= w_rd;
      if (w_rd) begin
        r_rd_data <= w_in_range ? r_mem[w_idx] : '0;
      end
    end
  end

  // Rejection pulse and saturating rejection counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_err <= w_rej;
      if (w_rej) begin
        r_err_cnt <= sat_inc8(r_err_cnt);
      end
    end
  end

  dm_rd_pipe #(
    .DATA_W  (DATA_W),
    .RD_PIPE (RD_PIPE)
  ) u_rd_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_vld  (r_rd_vld),
    .i_data (r_rd_data),
    .o_vld  (rd_vld),
    .o_data (rd_data)
  );

  assign err     = r_err;
  assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dm_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_param
//  Description : Self-checking bench for dm_param. Two instances (RD_PIPE=0
//                and RD_PIPE=1) share one stimulus stream; expected read
//                results and their arrival cycles are queued per instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_param;

  localparam int DW = 32;
  localparam int AW = 14;
  localparam int DP = 8192;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic          re;
  logic          we;
  logic [3:0]    be;
  logic [DW-1:0] wdata;

  logic [DW-1:0] rd_data0, rd_data1;
  logic          rd_vld0,  rd_vld1;
  logic          err0,     err1;
  logic [7:0]    err_cnt0, err_cnt1;

  dm_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .RD_PIPE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .re(re), .we(we), .be(be),
    .wrt_data(wdata), .rd_data(rd_data0), .rd_vld(rd_vld0), .err(err0),
    .err_cnt(err_cnt0)
  );

  dm_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .RD_PIPE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .re(re), .we(we), .be(be),
    .wrt_data(wdata), .rd_data(rd_data1), .rd_vld(rd_vld1), .err(err1),
    .err_cnt(err_cnt1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        e0, e1;
  logic [31:0] mdl [int];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Both instances must agree on err and err_cnt
  task automatic chk_err(input string tag, input logic e, input logic [7:0] c);
    check({tag, "_err0"}, {31'd0, err0}, {31'd0, e});
    check({tag, "_cnt0"}, {24'd0, err_cnt0}, {24'd0, c});
    check({tag, "_err1"}, {31'd0, err1}, {31'd0, e});
    check({tag, "_cnt1"}, {24'd0, err_cnt1}, {24'd0, c});
  endtask

  // Present one request for one edge; reads queue their expected result
  task automatic drive(input logic r, input logic w, input int a,
                       input logic [3:0] b, input logic [31:0] d);
    logic [31:0] v;
    re    = r;
    we    = w;
    addr  = AW'(a);
    be    = b;
    wdata = d;
    if (rst_n && r && !w) begin
      v = 32'd0;
      if (a < DP && mdl.exists(a)) v = mdl[a];
      q0.push_back('{cyc + 1, v});
      q1.push_back('{cyc + 2, v});
    end
    if (rst_n && w && !r && a < DP) begin
      v = mdl.exists(a) ? mdl[a] : 32'd0;
      for (int i = 0; i < 4; i++) if (b[i]) v[8*i +: 8] = d[8*i +: 8];
      mdl[a] = v;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    re = 1'b0;
    we = 1'b0;
    be = 4'h0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on each valid, flag unexpected or overdue results
  always @(negedge clk) begin
    if (rd_vld0) begin
      if (q0.size() == 0) check("rd0_unexpected_vld", 32'd1, 32'd0);
      else begin
        e0 = q0.pop_front();
        check("rd0_data", rd_data0, e0.data);
        check("rd0_cycle", cyc, e0.cyc);
      end
    end else if (q0.size() > 0 && q0[0].cyc < cyc) begin
      check("rd0_timeout", 32'd0, 32'd1);
      void'(q0.pop_front());
    end
    if (rd_vld1) begin
      if (q1.size() == 0) check("rd1_unexpected_vld", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        check("rd1_data", rd_data1, e1.data);
        check("rd1_cycle", cyc, e1.cyc);
      end
    end else if (q1.size() > 0 && q1[0].cyc < cyc) begin
      check("rd1_timeout", 32'd0, 32'd1);
      void'(q1.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    re    = 1'b0;
    we    = 1'b0;
    addr  = '0;
    be    = 4'h0;
    wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld0",  {31'd0, rd_vld0}, 32'd0);
    check("rst_data0", rd_data0, 32'd0);
    check("rst_vld1",  {31'd0, rd_vld1}, 32'd0);
    check("rst_data1", rd_data1, 32'd0);
    chk_err("rst", 1'b0, 8'd0);
    rst_n = 1'b1;
    idle(1);

    // Full write then immediate read-back
    drive(1'b0, 1'b1, 5, 4'hF, 32'hDEADBEEF);
    drive(1'b1, 1'b0, 5, 4'h0, 32'h0);
    idle(3);

    // Partial write of lane 1 only
    drive(1'b0, 1'b1, 5, 4'h2, 32'h0000AB00);
    drive(1'b1, 1'b0, 5, 4'h0, 32'h0);
    idle(3);

    // All-zero byte enables: no change, no error
    drive(1'b0, 1'b1, 5, 4'h0, 32'hFFFFFFFF);
    chk_err("be0", 1'b0, 8'd0);
    drive(1'b1, 1'b0, 5, 4'h0, 32'h0);
    idle(3);

    // Fill a few words, then back-to-back reads
    drive(1'b0, 1'b1, 1,   4'hF, 32'h11110001);
    drive(1'b0, 1'b1, 2,   4'hF, 32'h22220002);
    drive(1'b0, 1'b1, 3,   4'hF, 32'h33330003);
    drive(1'b0, 1'b1, 808, 4'hF, 32'h11223344);
    drive(1'b1, 1'b0, 1, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 2, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 3, 4'h0, 32'h0);
    idle(4);
    check("hold_data0", rd_data0, 32'h33330003);
    check("hold_data1", rd_data1, 32'h33330003);
    check("hold_vld0",  {31'd0, rd_vld0}, 32'd0);

    // Conflict: rejected, address untouched
    drive(1'b1, 1'b1, 5, 4'hF, 32'h0);
    chk_err("conflict", 1'b1, 8'd1);
    idle(1);
    chk_err("conflict_after", 1'b0, 8'd1);
    drive(1'b1, 1'b0, 5, 4'h0, 32'h0);
    idle(3);

    // Out-of-range read answers zero; out-of-range write must not alias
    drive(1'b1, 1'b0, 8192, 4'h0, 32'h0);
    chk_err("oor_rd", 1'b1, 8'd2);
    drive(1'b0, 1'b1, 9000, 4'hF, 32'hCAFEF00D);
    chk_err("oor_wr", 1'b1, 8'd3);
    drive(1'b1, 1'b0, 808, 4'h0, 32'h0);
    chk_err("oor_after", 1'b0, 8'd3);
    idle(3);

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) drive(1'b1, 1'b1, 5, 4'hF, 32'h0);
    chk_err("sat", 1'b1, 8'd255);
    idle(1);
    chk_err("sat_after", 1'b0, 8'd255);

    // Reset in the middle of a read: result discarded, counter cleared
    re   = 1'b1;
    we   = 1'b0;
    addr = AW'(5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    re    = 1'b0;
    #1;
    check("midrst_vld0", {31'd0, rd_vld0}, 32'd0);
    check("midrst_vld1", {31'd0, rd_vld1}, 32'd0);
    check("midrst_data0", rd_data0, 32'd0);
    chk_err("midrst", 1'b0, 8'd0);
    idle(1);
    // A write while in reset must be ignored
    drive(1'b0, 1'b1, 5, 4'hF, 32'h00000000);
    idle(2);
    rst_n = 1'b1;
    idle(4);
    drive(1'b1, 1'b0, 5, 4'h0, 32'h0);
    idle(4);
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    check("final_cnt0", {24'd0, err_cnt0}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dm_param.md
DM_PARAM -- requirements
Module: dm_param

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, meaning word width in bits (multiple of 8).
REQ-002 The block SHALL take parameter ADDR_W, default 13, meaning address width.
REQ-003 The block SHALL take parameter DEPTH, default 8192, meaning number of words (DEPTH <= 2**ADDR_W).
REQ-004 The block SHALL take parameter RD_PIPE, default 0, meaning extra read output register stages (0 or 1).
REQ-005 The block SHALL provide the port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL provide the port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL provide the port addr, input, ADDR_W bits: word address.
REQ-008 The block SHALL provide the port re, input, 1 bit: read request.
REQ-009 The block SHALL provide the port we, input, 1 bit: write request.
REQ-010 The block SHALL provide the port be, input, DATA_W/8 bits: byte write enables, where bit i covers bits 8i+7..8i.
REQ-011 The block SHALL provide the port wrt_data, input, DATA_W bits: write data.
REQ-012 The block SHALL provide the port rd_data, output, DATA_W bits: read data.
REQ-013 The block SHALL provide the port rd_vld, output, 1 bit: one-cycle pulse marking valid rd_data.
REQ-014 The block SHALL provide the port err, output, 1 bit: one-cycle pulse marking a rejected request.
REQ-015 The block SHALL provide the port err_cnt, output, 8 bits: saturating count of rejected requests.

Function
REQ-016 Request types: read = re&~we, write = we&~re, conflict = re&we, idle = ~re&~we, sampled each rising clk.
REQ-017 A write to addr < DEPTH SHALL update only the byte lanes whose be bit is 1; other lanes keep their contents.
REQ-018 A write with be all-zero SHALL be a no-op and SHALL NOT assert err.
REQ-019 A read to addr < DEPTH SHALL present the word on rd_data, with rd_vld=1, exactly 1+RD_PIPE cycles after the request edge.
REQ-020 A read issued the cycle after a write to the same address SHALL return the newly written data.
REQ-021 Reads SHALL be fully pipelined: back-to-back reads every cycle SHALL produce back-to-back rd_vld pulses in order.
REQ-022 rd_data SHALL hold its last value while rd_vld=0.
REQ-023 A conflict request SHALL perform neither access and SHALL pulse err one cycle after the request edge.
REQ-024 A read or write with addr >= DEPTH SHALL leave memory unchanged and SHALL pulse err one cycle after the request edge.
REQ-025 An out-of-range read SHALL still produce rd_vld at normal latency with rd_data = 0.
REQ-026 err_cnt SHALL increment by 1 on each err pulse and SHALL saturate at 255 (no wrap).
REQ-027 Idle cycles SHALL leave all outputs except rd_vld and err unchanged.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately clear rd_data, rd_vld, err, err_cnt and all read pipeline registers to 0.
REQ-029 Memory contents SHALL NOT be reset; they SHALL retain prior values across reset.
REQ-030 A read in flight when reset asserts SHALL be discarded, with no rd_vld after reset release.
REQ-031 Requests presented while rst_n=0 SHALL be ignored.

Structure
REQ-032 Package dm_pkg SHALL hold default DATA_W/ADDR_W/DEPTH constants and the request-type encoding (IDLE, RD, WR, CONFLICT).
REQ-033 The RD_PIPE output stage (data plus valid register, bypassed when RD_PIPE=0) SHALL be the sub-module dm_rd_pipe; all else stays in dm_param.

Verification
REQ-034 RD_PIPE=0: write 0xDEADBEEF to addr 5 with be=0xF, then read addr 5 -> rd_data=0xDEADBEEF with rd_vld=1 one cycle after the read edge.
REQ-035 Partial write: be=0x2 with data 0x0000AB00 over 0xDEADBEEF at addr 5 -> read returns 0xDEADABEF.
REQ-036 RD_PIPE=1: reads of addr 1,2,3 on consecutive cycles -> three consecutive rd_vld pulses starting 2 cycles after the first read edge, in order.
REQ-037 re=we=1 at addr 5 -> err pulse, err_cnt 0->1, addr 5 unchanged; read of addr 8192 (DEPTH=8192, ADDR_W=14) -> err pulse, rd_data=0 with rd_vld.
REQ-038 Drive 300 conflicts -> err_cnt stops at 255; assert rst_n=0 mid-read -> rd_vld never pulses, err_cnt=0, and addr 5 still reads 0xDEADABEF after release.
